// File: rtl/pb_di_crc_monitor.sv
// pb_di_crc_monitor: passive integrity checker for one packet-builder job.
// Re-reads NUM_CHK payload bytes and the CRC-8 trailer and compares them.
module pb_di_crc_monitor #(
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = 4,
  parameter int NUM_CHK   = 2,
  parameter int TIMEOUT   = 1024,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chk_en,
  input  logic                     err_clr,
  input  logic                     pb_start,
  input  logic                     pb_irq,
  input  logic                     pb_crc_en,
  input  logic [7:0]               pb_crc_val,
  input  logic [ADDR_W-1:0]        pb_addr_in,
  input  logic [ADDR_W-1:0]        pb_addr_out,
  input  logic [3:0]               pb_data_sel,
  input  logic [CNT_W-1:0]         pb_byte_cnt,
  input  logic [NUM_CHK*CNT_W-1:0] chk_idx,
  output logic [ADDR_W-1:0]        inmem_addr,
  input  logic [31:0]              inmem_data,
  output logic [ADDR_W-1:0]        outmem_addr,
  input  logic [31:0]              outmem_data,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CHK-1:0]       di_err_mask,
  output logic                     crc_err,
  output logic                     timeout_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int PH_W = CNT_W + 2;
  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC_RD,
    S_DI_RD,
    S_WAIT_IRQ,
    S_OUT_RD,
    S_REPORT
  } state_t;

  state_t                     r_state;
  logic [PH_W-1:0]            r_ph;
  logic [TM_W-1:0]            r_tmr;
  logic                       r_crc_en;
  logic [7:0]                 r_crc_val;
  logic [ADDR_W-1:0]          r_addr_in;
  logic [ADDR_W-1:0]          r_addr_out;
  logic [3:0]                 r_sel;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_CHK*CNT_W-1:0]   r_idx;
  logic                       r_irq_seen;
  logic [7:0]                 r_crc;
  logic [7:0]                 r_in_byte [NUM_CHK];
  logic [NUM_CHK-1:0]         r_mis;

  logic [CNT_W-1:0]           w_idx   [NUM_CHK];
  logic [ADDR_W-1:0]          w_iaddr [NUM_CHK];
  logic [ADDR_W-1:0]          w_oaddr [NUM_CHK+1];
  logic [NUM_CHK-1:0]         w_valid;
  logic [ADDR_W-1:0]          w_len;
  logic [ADDR_W-1:0]          w_cnt4;
  logic [PH_W-1:0]            w_cnt_ph;
  logic [CNT_W-1:0]           w_k;
  logic [7:0]                 w_crc_exp;
  logic                       w_any_err;
  logic                       w_unused;

  function automatic logic f_mode_ok(
    input logic [3:0]       sel,
    input logic [CNT_W-1:0] idx
  );
    if (sel == 4'd0)
      return idx[1:0] == 2'b00;
    else if (sel == 4'd1)
      return ~idx[1];
    else
      return 1'b1;
  endfunction

  // Position of an input byte inside the packed payload.
  function automatic logic [ADDR_W-1:0] f_pos(
    input logic [3:0]       sel,
    input logic [CNT_W-1:0] idx
  );
    logic [ADDR_W-1:0] q;
    q = ADDR_W'(idx >> 2);
    if (sel == 4'd0)
      return q;
    else if (sel == 4'd1)
      return (q << 1) + ADDR_W'(idx[0]);
    else
      return ADDR_W'(idx);
  endfunction

  // CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] f_crc8(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] x;
    x = c ^ d;
    for (int b = 0; b < 8; b++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  assign w_cnt_ph  = PH_W'(r_cnt);
  assign w_k       = CNT_W'(r_ph - PH_W'(1));
  assign w_crc_exp = r_crc_en ? r_crc : r_crc_val;
  assign w_cnt4    = ADDR_W'(r_cnt >> 2);
  assign w_any_err = (|di_err_mask) | crc_err | timeout_err;
  assign w_unused  = ^{inmem_data[31:8], outmem_data[31:8]};

  always_comb begin
    if (r_sel == 4'd0)
      w_len = w_cnt4 + ADDR_W'(1);
    else if (r_sel == 4'd1)
      w_len = (w_cnt4 << 1)
            + ADDR_W'(r_cnt[1] | r_cnt[0])
            + ADDR_W'(1);
    else
      w_len = ADDR_W'(r_cnt) + ADDR_W'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_CHK; i++) begin
      w_idx[i]   = r_idx[i*CNT_W +: CNT_W];
      w_valid[i] = (w_idx[i] <= r_cnt)
                 && f_mode_ok(r_sel, w_idx[i]);
      w_iaddr[i] = r_addr_in + ADDR_W'(w_idx[i]);
      w_oaddr[i] = r_addr_out + ADDR_W'(2)
                 + f_pos(r_sel, w_idx[i]);
    end
    w_oaddr[NUM_CHK] = r_addr_out + ADDR_W'(2) + w_len;
  end

  always_comb begin
    inmem_addr  = '0;
    outmem_addr = '0;
    unique case (r_state)
      S_CRC_RD: begin
        if (r_ph <= w_cnt_ph)
          inmem_addr = r_addr_in + ADDR_W'(r_ph);
      end
      S_DI_RD: begin
        for (int i = 0; i < NUM_CHK; i++)
          if (r_ph == PH_W'(i))
            inmem_addr = w_iaddr[i];
      end
      S_OUT_RD: begin
        for (int i = 0; i <= NUM_CHK; i++)
          if (r_ph == PH_W'(i))
            outmem_addr = w_oaddr[i];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_tmr       <= '0;
      r_crc_en    <= 1'b0;
      r_crc_val   <= '0;
      r_addr_in   <= '0;
      r_addr_out  <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_irq_seen  <= 1'b0;
      r_crc       <= 8'h00;
      r_mis       <= '0;
      for (int i = 0; i < NUM_CHK; i++)
        r_in_byte[i] <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      di_err_mask <= '0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr)
        err_cnt <= '0;
      if (r_state != S_IDLE && r_state != S_REPORT
          && !chk_en) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        if (pb_irq && r_state != S_IDLE)
          r_irq_seen <= 1'b1;
        unique case (r_state)
          S_IDLE: begin
            if (pb_start && chk_en) begin
              r_crc_en    <= pb_crc_en;
              r_crc_val   <= pb_crc_val;
              r_addr_in   <= pb_addr_in;
              r_addr_out  <= pb_addr_out;
              r_sel       <= pb_data_sel;
              r_cnt       <= pb_byte_cnt;
              r_idx       <= chk_idx;
              r_ph        <= '0;
              r_crc       <= 8'h00;
              r_irq_seen  <= 1'b0;
              busy        <= 1'b1;
              di_err_mask <= '0;
              crc_err     <= 1'b0;
              timeout_err <= 1'b0;
              r_state     <= pb_crc_en ? S_CRC_RD
                                       : S_DI_RD;
            end
          end
          S_CRC_RD: begin
            // Data for offset ph-1 is on the bus now.
            if (r_ph != '0 && f_mode_ok(r_sel, w_k))
              r_crc <= f_crc8(r_crc, inmem_data[7:0]);
            if (r_ph == w_cnt_ph + PH_W'(1)) begin
              r_state <= S_DI_RD;
              r_ph    <= '0;
            end else begin
              r_ph <= r_ph + PH_W'(1);
            end
          end
          S_DI_RD: begin
            for (int i = 0; i < NUM_CHK; i++)
              if (r_ph == PH_W'(i + 1))
                r_in_byte[i] <= inmem_data[7:0];
            if (r_ph == PH_W'(NUM_CHK)) begin
              r_state <= S_WAIT_IRQ;
              r_ph    <= '0;
              r_tmr   <= '0;
            end else begin
              r_ph <= r_ph + PH_W'(1);
            end
          end
          S_WAIT_IRQ: begin
            if (pb_irq || r_irq_seen) begin
              r_state <= S_OUT_RD;
              r_ph    <= '0;
            end else if (r_tmr == TM_W'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_REPORT;
            end else begin
              r_tmr <= r_tmr + TM_W'(1);
            end
          end
          S_OUT_RD: begin
            for (int i = 0; i < NUM_CHK; i++)
              if (r_ph == PH_W'(i + 1))
                r_mis[i] <= w_valid[i]
                  && (outmem_data[7:0] != r_in_byte[i]);
            if (r_ph == PH_W'(NUM_CHK + 1)) begin
              di_err_mask <= r_mis;
              crc_err     <= outmem_data[7:0] != w_crc_exp;
              done        <= 1'b1;
              r_state     <= S_REPORT;
            end else begin
              r_ph <= r_ph + PH_W'(1);
            end
          end
          S_REPORT: begin
            // A clear in the same cycle restarts the count at this job.
            if (w_any_err) begin
              if (err_clr)
                err_cnt <= ERR_CNT_W'(1);
              else if (~&err_cnt)
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pb_di_crc_monitor.sv
// tb_pb_di_crc_monitor: directed bench with memory models and a
// scoreboard of expected job results.
module tb_pb_di_crc_monitor;

  localparam int AW  = 14;
  localparam int CW  = 4;
  localparam int NC  = 2;
  localparam int TMO = 16;
  localparam int EW  = 8;
  localparam int AI  = 'h100;
  localparam int AO  = 'h200;

  typedef struct {
    logic [NC-1:0] mask;
    logic          crc;
    logic          tmo;
    int            dcyc;
    logic [EW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             chk_en;
  logic             err_clr;
  logic             pb_start;
  logic             pb_irq;
  logic             pb_crc_en;
  logic [7:0]       pb_crc_val;
  logic [AW-1:0]    pb_addr_in;
  logic [AW-1:0]    pb_addr_out;
  logic [3:0]       pb_data_sel;
  logic [CW-1:0]    pb_byte_cnt;
  logic [NC*CW-1:0] chk_idx;
  logic [AW-1:0]    inmem_addr;
  logic [31:0]      inmem_data;
  logic [AW-1:0]    outmem_addr;
  logic [31:0]      outmem_data;
  logic             busy;
  logic             done;
  logic [NC-1:0]    di_err_mask;
  logic             crc_err;
  logic             timeout_err;
  logic [EW-1:0]    err_cnt;

  pb_di_crc_monitor #(
    .ADDR_W(AW), .CNT_W(CW), .NUM_CHK(NC),
    .TIMEOUT(TMO), .ERR_CNT_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .chk_en(chk_en),
    .err_clr(err_clr), .pb_start(pb_start),
    .pb_irq(pb_irq), .pb_crc_en(pb_crc_en),
    .pb_crc_val(pb_crc_val), .pb_addr_in(pb_addr_in),
    .pb_addr_out(pb_addr_out),
    .pb_data_sel(pb_data_sel),
    .pb_byte_cnt(pb_byte_cnt), .chk_idx(chk_idx),
    .inmem_addr(inmem_addr), .inmem_data(inmem_data),
    .outmem_addr(outmem_addr),
    .outmem_data(outmem_data), .busy(busy),
    .done(done), .di_err_mask(di_err_mask),
    .crc_err(crc_err), .timeout_err(timeout_err),
    .err_cnt(err_cnt)
  );

  logic [7:0] imem [0:(1<<AW)-1];
  logic [7:0] omem [0:(1<<AW)-1];

  always @(posedge clk) begin
    inmem_data  <= {24'hA5C3E1, imem[inmem_addr]};
    outmem_data <= {24'h5A3C1E, omem[outmem_addr]};
  end

  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic [7:0] exp_cnt;
  int         g_pos [16];
  bit         g_ok  [16];
  int         g_crcpos;
  logic [7:0] g_crc;
  int         reads;
  int         ndone;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_ser(
    input logic [7:0] ci, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = ci;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic bit elig(input logic [3:0] sel,
                              input int k);
    if (sel == 0) return (k % 4) == 0;
    if (sel == 1) return (k % 4) < 2;
    return 1'b1;
  endfunction

  task automatic load(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++)
      imem[AI+k] = base + 8'(k);
  endtask

  // Builds the packet the builder would emit.
  task automatic build(input logic [3:0] sel,
                       input int cnt, input bit cen,
                       input logic [7:0] cval);
    int j;
    logic [7:0] c;
    j = 0;
    c = 8'h00;
    for (int k = 0; k < 16; k++) begin
      g_ok[k]  = 1'b0;
      g_pos[k] = 0;
    end
    omem[AO]   = 8'h5A;
    omem[AO+1] = 8'hC3;
    for (int k = 0; k <= cnt; k++) begin
      if (elig(sel, k)) begin
        g_ok[k]  = 1'b1;
        g_pos[k] = AO + 2 + j;
        omem[AO+2+j] = imem[AI+k];
        c = crc_ser(c, imem[AI+k]);
        j++;
      end
    end
    g_crcpos = AO + 2 + j;
    g_crc    = c;
    omem[g_crcpos] = cen ? c : cval;
  endtask

  task automatic run_job(input string tag,
                         input logic [3:0] sel,
                         input int cnt, input bit cen,
                         input logic [7:0] cval,
                         input int i1, input int i0,
                         input int irq_dly,
                         input bit clr);
    exp_t e;
    exp_t got;
    int w, c, idx;
    bit seen, err;
    w = (cen ? cnt + 2 : 0) + NC + 1;
    if (irq_dly < 0) begin
      e.mask = '0;
      e.crc  = 1'b0;
      e.tmo  = 1'b1;
      e.dcyc = w + TMO;
    end else begin
      for (int ch = 0; ch < NC; ch++) begin
        idx = (ch == 1) ? i1 : i0;
        e.mask[ch] = g_ok[idx]
          && (omem[g_pos[idx]] != imem[AI+idx]);
      end
      e.crc  = omem[g_crcpos] != (cen ? g_crc : cval);
      e.tmo  = 1'b0;
      e.dcyc = ((irq_dly > w) ? irq_dly : w) + NC + 3;
    end
    err = (|e.mask) | e.crc | e.tmo;
    if (clr) exp_cnt = err ? 8'd1 : 8'd0;
    else if (err && exp_cnt != 8'hFF) exp_cnt++;
    e.cnt = exp_cnt;
    sb.push_back(e);

    pb_data_sel = sel;
    pb_byte_cnt = CW'(cnt);
    pb_crc_en   = cen;
    pb_crc_val  = cval;
    pb_addr_in  = AW'(AI);
    pb_addr_out = AW'(AO);
    chk_idx     = {CW'(i1), CW'(i0)};
    pb_start    = 1'b1;
    @(posedge clk); #1;
    pb_start    = 1'b0;
    pb_data_sel = sel ^ 4'h3;
    pb_byte_cnt = ~CW'(cnt);
    pb_crc_en   = ~cen;
    pb_crc_val  = ~cval;
    pb_addr_in  = AW'(AI + 'h40);
    pb_addr_out = AW'(AO + 'h40);
    chk_idx     = ~{CW'(i1), CW'(i0)};
    c = 0;
    seen = 1'b0;
    reads = 0;
    while (!seen && c <= 150) begin
      if (inmem_addr !== '0) reads++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        pb_irq   = (c == irq_dly);
        pb_start = (c == 3);
        @(posedge clk); #1;
        c++;
      end
    end
    pb_irq   = 1'b0;
    pb_start = 1'b0;
    got = sb.pop_front();
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".done_cyc"}, c, got.dcyc);
      chk({tag, ".mask"}, 32'(di_err_mask), 32'(got.mask));
      chk({tag, ".crc_err"}, 32'(crc_err), 32'(got.crc));
      chk({tag, ".tmo"}, 32'(timeout_err), 32'(got.tmo));
      err_clr = clr;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(got.cnt));
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".held"}, 32'(di_err_mask), 32'(got.mask));
    end
  endtask

  task automatic quiet_wait(input int n);
    ndone = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      imem[a] = 8'h00;
      omem[a] = 8'h00;
    end
    reset = 1'b0;
    chk_en = 1'b1;
    err_clr = 1'b0;
    pb_start = 1'b0;
    pb_irq = 1'b0;
    pb_crc_en = 1'b0;
    pb_crc_val = '0;
    pb_addr_in = '0;
    pb_addr_out = '0;
    pb_data_sel = '0;
    pb_byte_cnt = '0;
    chk_idx = '0;
    exp_cnt = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.mask", 32'(di_err_mask), 32'd0);
    chk("rst.flags", 32'({crc_err, timeout_err}), 32'd0);
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
    chk("rst.addr", 32'({inmem_addr, outmem_addr}), 32'd0);

    load(6, 8'h01);
    build(4'd2, 5, 1'b1, 8'h00);
    run_job("t1", 4'd2, 5, 1'b1, 8'h00, 3, 0, 20, 1'b0);
    chk("t1.reads", reads, 5 + 1 + NC);

    omem[AO+5] = omem[AO+5] ^ 8'h40;
    run_job("t2", 4'd2, 5, 1'b1, 8'h00, 3, 0, 20, 1'b0);

    load(10, 8'h11);
    build(4'd1, 9, 1'b1, 8'h00);
    chk("t3.crcpos", g_crcpos, AO + 8);
    run_job("t3", 4'd1, 9, 1'b1, 8'h00, 9, 2, 20, 1'b0);

    build(4'd2, 5, 1'b0, 8'hA5);
    omem[g_crcpos] = 8'hA4;
    run_job("t4", 4'd2, 5, 1'b0, 8'hA5, 4, 1, 5, 1'b0);
    chk("t4.reads", reads, NC);

    load(8, 8'h31);
    build(4'd0, 7, 1'b1, 8'h00);
    run_job("t5", 4'd0, 7, 1'b1, 8'h00, 4, 0, 2, 1'b0);
    omem[AO+3] = omem[AO+3] ^ 8'h01;
    run_job("t6", 4'd0, 7, 1'b1, 8'h00, 4, 0, 2, 1'b0);

    load(8, 8'h71);
    build(4'd3, 3, 1'b1, 8'h00);
    omem[AO+9] = 8'hEE;
    run_job("t7", 4'd3, 3, 1'b1, 8'h00, 7, 1, 15, 1'b0);

    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_cnt = 8'd0;
    chk("clr.err_cnt", 32'(err_cnt), 32'd0);

    for (int n = 0; n < 256; n++)
      run_job("tmo", 4'd2, 5, 1'b0, 8'h00, 3, 0, -1, 1'b0);
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);

    run_job("clrinc", 4'd2, 5, 1'b0, 8'h00, 3, 0, -1, 1'b1);

    build(4'd2, 5, 1'b0, 8'h5C);
    pb_data_sel = 4'd2;
    pb_byte_cnt = CW'(5);
    pb_crc_en   = 1'b0;
    pb_addr_in  = AW'(AI);
    pb_addr_out = AW'(AO);
    pb_start    = 1'b1;
    @(posedge clk); #1;
    pb_start = 1'b0;
    chk_en   = 1'b0;
    quiet_wait(30);
    chk_en = 1'b1;
    chk("abort.done", ndone, 0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.err_cnt", 32'(err_cnt), 32'(exp_cnt));

    pb_crc_en   = 1'b1;
    pb_byte_cnt = CW'(9);
    pb_start    = 1'b1;
    @(posedge clk); #1;
    pb_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.err_cnt", 32'(err_cnt), 32'd0);
    chk("rstmid.flags",
        32'({di_err_mask, crc_err, timeout_err}), 32'd0);
    chk("rstmid.addr", 32'(inmem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 8'd0;
    quiet_wait(30);
    chk("rstmid.done", ndone, 0);

    load(6, 8'h01);
    build(4'd2, 5, 1'b1, 8'h00);
    run_job("post", 4'd2, 5, 1'b1, 8'h00, 3, 0, 20, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_di_crc_monitor.md
Name: pb_di_crc_monitor

Overview:
- Parametrised successor to the single-byte packet-builder integrity checker.
- Passively observes one packet-builder job and checks NUM_CHK configurable payload bytes (not one) against the built packet.
- Independently recomputes CRC-8 over the payload, supports a completion timeout, and keeps a saturating per-run error counter.
- Sits beside the packet builder on dedicated read ports of the incoming and outgoing memories; usable in simulation and formal.

Parameters:
- ADDR_W, 14, byte-address width of both memories.
- CNT_W, 4, width of pb_byte_cnt and of each checked-byte index.
- NUM_CHK, 2, number of payload bytes checked per job (1..8).
- TIMEOUT, 1024, maximum cycles from end of input phase to pb_irq.
- ERR_CNT_W, 8, width of err_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- chk_en  in  1  monitor enable.
- err_clr  in  1  synchronous clear of err_cnt.
- pb_start  in  1  builder job start pulse.
- pb_irq  in  1  builder done pulse.
- pb_crc_en  in  1  1 = CRC computed; 0 = pb_crc_val used.
- pb_crc_val  in  8  predefined CRC.
- pb_addr_in  in  ADDR_W  payload base in incoming memory.
- pb_addr_out  in  ADDR_W  packet base in outgoing memory.
- pb_data_sel  in  4  packing mode (0: byte0 of each word; 1: bytes 0,1 of each word; other: every byte).
- pb_byte_cnt  in  CNT_W  offset of last input byte.
- chk_idx  in  NUM_CHK*CNT_W  input-byte offsets to check; channel i is at [i*CNT_W +: CNT_W].
- inmem_addr  out  ADDR_W  incoming-memory read address.
- inmem_data  in  32  read data; the byte is in [7:0], returned one cycle after the address.
- outmem_addr  out  ADDR_W  outgoing-memory read address, same timing as inmem.
- outmem_data  in  32  read data, byte in [7:0].
- busy  out  1  job being monitored.
- done  out  1  one-cycle pulse when results are valid.
- di_err_mask  out  NUM_CHK  per-channel mismatch, held from done until the next accepted start.
- crc_err  out  1  CRC mismatch, held like di_err_mask.
- timeout_err  out  1  pb_irq missing, held like di_err_mask.
- err_cnt  out  ERR_CNT_W  saturating count of failed jobs.

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC register 0x00.
- Configuration sampling:
  - Job accepted on a pb_start && chk_en cycle in IDLE.
  - All pb_* config and chk_idx are registered on acceptance; later input changes are ignored.
  - pb_start while busy is ignored.
- Channel eligibility: channel i is valid iff idx <= pb_byte_cnt and
  - mode 0: idx[1:0]==0;
  - mode 1: idx[1]==0;
  - otherwise: always.
  - Invalid channels are skipped and never report an error.
- Output packet position: 2 header bytes + payload index P + CRC at 2+L.
  - P: mode 0 = idx>>2; mode 1 = 2*(idx>>2)+idx[0]; otherwise idx.
  - L: mode 0 = (cnt>>2)+1; mode 1 = 2*(cnt>>2)+(cnt[1]|cnt[0])+1; otherwise cnt+1.
  - All sums are computed at ADDR_W and wrap modulo 2^ADDR_W.
- FSM:
  - IDLE → CRC_RD if pb_crc_en, else DI_RD.
  - CRC_RD:
    - Issues pb_addr_in+k for k=0..cnt, one per cycle, pipelined.
    - Data for offset k arrives at k+1 and is folded into crc_chk_calc (CRC-8, init 0x00) only if offset k is eligible under the mode rule.
    - Leaves after the data of the last offset; cnt+2 cycles total.
  - DI_RD: issues pb_addr_in+idx_i for i=0..NUM_CHK-1 and captures the bytes; NUM_CHK+1 cycles. → WAIT_IRQ.
  - WAIT_IRQ:
    - pb_irq → OUT_RD.
    - A pb_irq in any earlier busy state is latched and honoured on entry.
    - After TIMEOUT cycles with no pb_irq: set timeout_err → REPORT.
  - OUT_RD: reads pb_addr_out+2+P_i for each channel, then pb_addr_out+2+L; compares pipelined; NUM_CHK+2 cycles. → REPORT.
  - REPORT: done=1 for one cycle; if any error flag is set, err_cnt increments (saturating at all-ones). → IDLE.
- Address outputs are 0 when not issuing.
- Expected CRC: pb_crc_en ? computed : registered pb_crc_val.
- chk_en low in any busy state: abort to IDLE; no done, no flag update, err_cnt unchanged.
- err_clr:
  - Clears err_cnt.
  - Coincident with a REPORT increment, the result is 1 (clear, then count).
- reset asserted mid-job: immediate return to reset values.

Test Plan:
- Mode 2, cnt=5, crc_en=1, chk_idx={3,0}, payload 0x01..0x06, correct output image, irq after 20 cycles → done, di_err_mask=0, crc_err=0, err_cnt=0.
- Same job with output byte at pb_addr_out+5 corrupted → di_err_mask=2'b10, crc_err=0, err_cnt=1.
- Mode 1, cnt=9, chk_idx={9,2} → channel for idx 2 skipped; idx 9 checked at out offset 2+5=7; CRC read at offset 2+6=8; correct data → no errors.
- crc_en=0, pb_crc_val=0xA5, outmem CRC byte 0xA4 → crc_err=1, CRC_RD state never entered.
- No pb_irq, TIMEOUT=16 → timeout_err=1 exactly 16 cycles after WAIT_IRQ entry; err_cnt saturates at 255 after 256 such jobs.
- chk_en dropped in DI_RD, then reset pulsed mid-CRC_RD → no done in either case; outputs return to 0.
